// File: rtl/cpu_pkg.sv
// Shared opcode/function encodings, datapath width and the multiply/divide FSM state type
// for the 16-bit pipelined CPU.
package cpu_pkg;

  localparam int DATA_WIDTH = 16;

  localparam logic [3:0] OP_RTYPE = 4'b0000;

  localparam logic [3:0] FN_ADD = 4'b0000;
  localparam logic [3:0] FN_SUB = 4'b0001;
  localparam logic [3:0] FN_AND = 4'b0010;
  localparam logic [3:0] FN_OR  = 4'b0011;
  localparam logic [3:0] FN_MUL = 4'b0100;
  localparam logic [3:0] FN_DIV = 4'b0101;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } md_state_e;

endpackage

// File: rtl/ex_stage_if.sv
// ID/EX inputs, EX/MEM outputs and the flush/stall pair of the execute stage.
// master = upstream pipeline side, slave = ex_stage.
interface ex_stage_if import cpu_pkg::*; #(
  parameter int WIDTH = DATA_WIDTH
);
  logic             flush;
  logic [3:0]       opcode_EX;
  logic [3:0]       RA1_EX;
  logic [3:0]       RA2_EX;
  logic [3:0]       FN_offset_EX;
  logic [WIDTH-1:0] RD1_EX;
  logic [WIDTH-1:0] RD2_EX;
  logic [WIDTH-1:0] SE_offset_EX;
  logic             regWrite_EX;
  logic             r0Write_EX;
  logic             alusource_EX;
  logic             memRead_EX;
  logic             memWrite_EX;
  logic             memSource_EX;

  logic             ex_busy;
  logic [WIDTH-1:0] alu_MEM;
  logic [WIDTH-1:0] r0_MEM;
  logic [WIDTH-1:0] wdata_MEM;
  logic [3:0]       WA_MEM;
  logic             regWrite_MEM;
  logic             r0Write_MEM;
  logic             memRead_MEM;
  logic             memWrite_MEM;
  logic             memSource_MEM;

  modport master (
    output flush, opcode_EX, RA1_EX, RA2_EX, FN_offset_EX, RD1_EX, RD2_EX, SE_offset_EX,
           regWrite_EX, r0Write_EX, alusource_EX, memRead_EX, memWrite_EX, memSource_EX,
    input  ex_busy, alu_MEM, r0_MEM, wdata_MEM, WA_MEM,
           regWrite_MEM, r0Write_MEM, memRead_MEM, memWrite_MEM, memSource_MEM
  );

  modport slave (
    input  flush, opcode_EX, RA1_EX, RA2_EX, FN_offset_EX, RD1_EX, RD2_EX, SE_offset_EX,
           regWrite_EX, r0Write_EX, alusource_EX, memRead_EX, memWrite_EX, memSource_EX,
    output ex_busy, alu_MEM, r0_MEM, wdata_MEM, WA_MEM,
           regWrite_MEM, r0Write_MEM, memRead_MEM, memWrite_MEM, memSource_MEM
  );

endinterface

// File: rtl/muldiv_seq.sv
// Iterative signed multiply (shift-add) and divide (restoring), one step per cycle.
// The divider datapath only exists when EX_DIV_EN is defined.
module muldiv_seq import cpu_pkg::*; #(
  parameter int WIDTH = DATA_WIDTH,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_i,
  input  logic             abort_i,
`ifdef EX_DIV_EN
  input  logic             isDiv_i,
`endif
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  md_state_e          state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic               negRes_q, negRes_d;
  logic [WIDTH-1:0]   absA, absB;
  logic [WIDTH:0]     mulSum;
  logic [2*WIDTH-1:0] product;
`ifdef EX_DIV_EN
  logic               isDiv_q, isDiv_d;
  logic               negRem_q, negRem_d;
  logic               bZero_q, bZero_d;
  logic [WIDTH:0]     remShift, remSub;
  logic               remGe;
  logic [WIDTH-1:0]   quotient, remainder;
`endif

  // Magnitudes are unsigned, so the most negative operand still fits.
  assign absA   = a_i[WIDTH-1] ? -a_i : a_i;
  assign absB   = b_i[WIDTH-1] ? -b_i : b_i;
  assign mulSum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);

`ifdef EX_DIV_EN
  assign remShift = {hi_q, lo_q[WIDTH-1]};
  assign remGe    = remShift >= {1'b0, b_q};
  assign remSub   = remShift - {1'b0, b_q};
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    b_d      = b_q;
    negRes_d = negRes_q;
`ifdef EX_DIV_EN
    isDiv_d  = isDiv_q;
    negRem_d = negRem_q;
    bZero_d  = bZero_q;
`endif
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d  = RUN;
          cnt_d    = '0;
          hi_d     = '0;
          lo_d     = absA;
          b_d      = absB;
          negRes_d = a_i[WIDTH-1] ^ b_i[WIDTH-1];
`ifdef EX_DIV_EN
          isDiv_d  = isDiv_i;
          negRem_d = a_i[WIDTH-1];
          bZero_d  = (b_i == '0);
`endif
        end
      end
      RUN: begin
        if (abort_i) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            state_d = DONE;
          end
`ifdef EX_DIV_EN
          if (isDiv_q) begin
            hi_d = WIDTH'(remGe ? remSub : remShift);
            lo_d = {lo_q[WIDTH-2:0], remGe};
          end else
`endif
          begin
            hi_d = mulSum[WIDTH:1];
            lo_d = {mulSum[0], lo_q[WIDTH-1:1]};
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      b_q      <= '0;
      negRes_q <= 1'b0;
`ifdef EX_DIV_EN
      isDiv_q  <= 1'b0;
      negRem_q <= 1'b0;
      bZero_q  <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      b_q      <= b_d;
      negRes_q <= negRes_d;
`ifdef EX_DIV_EN
      isDiv_q  <= isDiv_d;
      negRem_q <= negRem_d;
      bZero_q  <= bZero_d;
`endif
    end
  end

  // Stall is raised in the accepting IDLE cycle as well, so ID/EX holds the op.
  assign busy_o  = !reset && ((state_q == IDLE && start_i) || state_q == RUN);
  assign done_o  = (state_q == DONE);
  assign product = negRes_q ? -{hi_q, lo_q} : {hi_q, lo_q};

`ifdef EX_DIV_EN
  assign quotient  = bZero_q ? '1 : (negRes_q ? -lo_q : lo_q);
  assign remainder = negRem_q ? -hi_q : hi_q;
  assign hi_o      = isDiv_q ? remainder : product[2*WIDTH-1:WIDTH];
  assign lo_o      = isDiv_q ? quotient  : product[WIDTH-1:0];
`else
  assign hi_o      = product[2*WIDTH-1:WIDTH];
  assign lo_o      = product[WIDTH-1:0];
`endif

endmodule

// File: rtl/ex_stage.sv
// Execute stage: operand select, single-cycle ALU, EX/MEM register and the iterative
// MUL/DIV unit. Signed DIV (FN 0101) is built only when EX_DIV_EN is defined.
module ex_stage import cpu_pkg::*; #(
  parameter int WIDTH = DATA_WIDTH,
  parameter int CNT_W = 4
) (
  input  logic     clk,
  input  logic     reset,
  ex_stage_if.slave bus_io
);

  logic             isRtype, isMem, fnLegal, isMulDiv, startMd;
  logic             mdBusy, mdDone, bubble;
  logic [WIDTH-1:0] opA, opB, aluRes, mdHi, mdLo;
  logic [WIDTH-1:0] alu_q, alu_d, r0_q, r0_d, wdata_q, wdata_d;
  logic [3:0]       wa_q, wa_d;
  logic [4:0]       ctrl_q, ctrl_d, ctrlIn;
  logic             unusedRa2;
`ifdef EX_DIV_EN
  logic             isDivOp;
`endif

  // RA2 only matters to hazard logic upstream.
  assign unusedRa2 = ^bus_io.RA2_EX;

  assign isRtype = (bus_io.opcode_EX == OP_RTYPE);
  assign isMem   = bus_io.memRead_EX | bus_io.memWrite_EX;
  assign opA     = bus_io.RD1_EX;
  assign opB     = bus_io.alusource_EX ? bus_io.SE_offset_EX : bus_io.RD2_EX;
  assign ctrlIn  = {bus_io.regWrite_EX, bus_io.r0Write_EX, bus_io.memRead_EX,
                    bus_io.memWrite_EX, bus_io.memSource_EX};

  always_comb begin
    aluRes   = '0;
    fnLegal  = 1'b1;
    isMulDiv = 1'b0;
`ifdef EX_DIV_EN
    isDivOp  = 1'b0;
`endif
    if (isMem) begin
      aluRes = bus_io.RD2_EX + bus_io.SE_offset_EX;
    end else if (isRtype) begin
      case (bus_io.FN_offset_EX)
        FN_ADD: aluRes = opA + opB;
        FN_SUB: aluRes = opA - opB;
        FN_AND: aluRes = opA & opB;
        FN_OR:  aluRes = opA | opB;
        FN_MUL: isMulDiv = 1'b1;
`ifdef EX_DIV_EN
        FN_DIV: begin
          isMulDiv = 1'b1;
          isDivOp  = 1'b1;
        end
`endif
        default: fnLegal = 1'b0;
      endcase
    end else begin
      aluRes = opA + opB;
    end
  end

  assign startMd = isMulDiv && !bus_io.flush;

  muldiv_seq #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_muldiv (
    .clk     (clk),
    .reset   (reset),
    .start_i (startMd),
    .abort_i (bus_io.flush),
`ifdef EX_DIV_EN
    .isDiv_i (isDivOp),
`endif
    .a_i     (opA),
    .b_i     (opB),
    .busy_o  (mdBusy),
    .done_o  (mdDone),
    .hi_o    (mdHi),
    .lo_o    (mdLo)
  );

  // A stalled or flushed cycle pushes an all-zero bubble into EX/MEM.
  assign bubble = bus_io.flush || mdBusy;

  always_comb begin
    alu_d   = '0;
    r0_d    = '0;
    wdata_d = '0;
    wa_d    = '0;
    ctrl_d  = '0;
    if (!bubble) begin
      wdata_d = bus_io.RD1_EX;
      wa_d    = bus_io.RA1_EX;
      if (mdDone) begin
        alu_d  = mdLo;
        r0_d   = mdHi;
        ctrl_d = ctrlIn;
      end else if (fnLegal) begin
        alu_d  = aluRes;
        ctrl_d = ctrlIn;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      alu_q   <= '0;
      r0_q    <= '0;
      wdata_q <= '0;
      wa_q    <= '0;
      ctrl_q  <= '0;
    end else begin
      alu_q   <= alu_d;
      r0_q    <= r0_d;
      wdata_q <= wdata_d;
      wa_q    <= wa_d;
      ctrl_q  <= ctrl_d;
    end
  end

  assign bus_io.ex_busy       = mdBusy;
  assign bus_io.alu_MEM       = alu_q;
  assign bus_io.r0_MEM        = r0_q;
  assign bus_io.wdata_MEM     = wdata_q;
  assign bus_io.WA_MEM        = wa_q;
  assign bus_io.regWrite_MEM  = ctrl_q[4];
  assign bus_io.r0Write_MEM   = ctrl_q[3];
  assign bus_io.memRead_MEM   = ctrl_q[2];
  assign bus_io.memWrite_MEM  = ctrl_q[1];
  assign bus_io.memSource_MEM = ctrl_q[0];

endmodule

// File: tb/tb_ex_stage.sv
// Directed self-checking bench for ex_stage; the DIV scenario adapts to EX_DIV_EN.
module tb_ex_stage;
  import cpu_pkg::*;

  localparam logic [5:0] C_RW  = 6'b100000;
  localparam logic [5:0] C_R0  = 6'b010000;
  localparam logic [5:0] C_SRC = 6'b001000;
  localparam logic [5:0] C_MR  = 6'b000100;
  localparam logic [5:0] C_MW  = 6'b000010;
  localparam logic [5:0] C_MS  = 6'b000001;
  localparam logic [3:0] OP_NOP = 4'hF;

  logic clk;
  logic reset;
  int   checksRun;
  int   checksPassed;

  ex_stage_if #(.WIDTH(16)) bus ();

  ex_stage #(.WIDTH(16), .CNT_W(4)) dut (
    .clk    (clk),
    .reset  (reset),
    .bus_io (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // ctrl = {regWrite, r0Write, alusource, memRead, memWrite, memSource}
  task automatic applyStimulus(input logic [3:0] op, input logic [3:0] fn, input logic [3:0] ra1,
                               input logic [15:0] rd1, input logic [15:0] rd2,
                               input logic [15:0] se, input logic [5:0] ctrl);
    bus.opcode_EX    = op;
    bus.FN_offset_EX = fn;
    bus.RA1_EX       = ra1;
    bus.RA2_EX       = 4'h0;
    bus.RD1_EX       = rd1;
    bus.RD2_EX       = rd2;
    bus.SE_offset_EX = se;
    {bus.regWrite_EX, bus.r0Write_EX, bus.alusource_EX,
     bus.memRead_EX, bus.memWrite_EX, bus.memSource_EX} = ctrl;
  endtask

  // Waits out a MUL/DIV that was just applied; returns with its result on the _MEM outputs.
  task automatic runLongOp(output int cycles, output bit bubbleBad);
    cycles    = 0;
    bubbleBad = 1'b0;
    #1;
    while (bus.ex_busy === 1'b1 && cycles < 40) begin
      cycles++;
      @(negedge clk);
      if ({bus.alu_MEM, bus.r0_MEM, bus.wdata_MEM, bus.WA_MEM, bus.regWrite_MEM, bus.r0Write_MEM,
           bus.memRead_MEM, bus.memWrite_MEM, bus.memSource_MEM} !== '0)
        bubbleBad = 1'b1;
    end
    @(posedge clk);
    #1;
    applyStimulus(OP_NOP, 4'h0, 4'h0, 16'h0, 16'h0, 16'h0, 6'b0);
    @(negedge clk);
  endtask

  task automatic test_reset;
    reset    = 1'b1;
    bus.flush = 1'b0;
    applyStimulus(OP_RTYPE, FN_ADD, 4'h5, 16'h0001, 16'h0002, 16'h0, C_RW);
    repeat (2) @(posedge clk);
    @(negedge clk);
    checksRun++;
    if ({bus.alu_MEM, bus.r0_MEM, bus.wdata_MEM, bus.WA_MEM, bus.regWrite_MEM, bus.r0Write_MEM,
         bus.memRead_MEM, bus.memWrite_MEM, bus.memSource_MEM} !== '0)
      $display("[TB] FAIL reset_outputs: got alu=%h wa=%h rw=%b expected all zero",
               bus.alu_MEM, bus.WA_MEM, bus.regWrite_MEM);
    else checksPassed++;
    applyStimulus(OP_RTYPE, FN_MUL, 4'h1, 16'h0003, 16'h0004, 16'h0, C_RW);
    #1;
    checksRun++;
    if (bus.ex_busy !== 1'b0)
      $display("[TB] FAIL reset_busy: got %b expected 0", bus.ex_busy);
    else checksPassed++;
    applyStimulus(OP_NOP, 4'h0, 4'h0, 16'h0, 16'h0, 16'h0, 6'b0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_add;
    @(negedge clk);
    applyStimulus(OP_RTYPE, FN_ADD, 4'h3, 16'h7FFF, 16'h0001, 16'h0, C_RW);
    #1;
    checksRun++;
    if (bus.ex_busy !== 1'b0) $display("[TB] FAIL add_busy: got %b expected 0", bus.ex_busy);
    else checksPassed++;
    @(negedge clk);
    checksRun++;
    if ({bus.alu_MEM, bus.WA_MEM, bus.regWrite_MEM, bus.r0Write_MEM, bus.r0_MEM} !==
        {16'h8000, 4'h3, 1'b1, 1'b0, 16'h0000})
      $display("[TB] FAIL add_result: got alu=%h wa=%h rw=%b r0w=%b r0=%h expected 8000/3/1/0/0000",
               bus.alu_MEM, bus.WA_MEM, bus.regWrite_MEM, bus.r0Write_MEM, bus.r0_MEM);
    else checksPassed++;
    applyStimulus(OP_NOP, 4'h0, 4'h0, 16'h0, 16'h0, 16'h0, 6'b0);
  endtask

  task automatic test_back_to_back;
    logic [3:0]  opT  [5] = '{OP_RTYPE, OP_RTYPE, OP_RTYPE, OP_RTYPE, 4'h7};
    logic [3:0]  fnT  [5] = '{FN_SUB, FN_AND, FN_OR, FN_ADD, 4'h0};
    logic [15:0] rd1T [5] = '{16'h0005, 16'hF0F0, 16'hF0F0, 16'h0010, 16'h1234};
    logic [15:0] rd2T [5] = '{16'h0007, 16'h3C3C, 16'h3C3C, 16'h5555, 16'h1111};
    logic [15:0] seT  [5] = '{16'h0000, 16'h0000, 16'h0000, 16'hFFFF, 16'h0000};
    logic [5:0]  cT   [5] = '{C_RW, C_RW, C_RW, C_RW | C_SRC, C_RW};
    logic [15:0] expT [5] = '{16'hFFFE, 16'h3030, 16'hFCFC, 16'h000F, 16'h2345};
    @(negedge clk);
    applyStimulus(opT[0], fnT[0], 4'h1, rd1T[0], rd2T[0], seT[0], cT[0]);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checksRun++;
      if ({bus.alu_MEM, bus.WA_MEM, bus.regWrite_MEM} !== {expT[i], 4'(i + 1), 1'b1})
        $display("[TB] FAIL b2b_op%0d: got alu=%h wa=%h rw=%b expected %h/%h/1",
                 i, bus.alu_MEM, bus.WA_MEM, bus.regWrite_MEM, expT[i], 4'(i + 1));
      else checksPassed++;
      if (i < 4) applyStimulus(opT[i+1], fnT[i+1], 4'(i + 2), rd1T[i+1], rd2T[i+1], seT[i+1], cT[i+1]);
      else       applyStimulus(OP_NOP, 4'h0, 4'h0, 16'h0, 16'h0, 16'h0, 6'b0);
    end
  endtask

  task automatic test_store;
    @(negedge clk);
    applyStimulus(4'hB, 4'h0, 4'h2, 16'hBEEF, 16'h0100, 16'hFFFE, C_MW);
    @(negedge clk);
    checksRun++;
    if ({bus.alu_MEM, bus.wdata_MEM, bus.memWrite_MEM, bus.regWrite_MEM, bus.memRead_MEM} !==
        {16'h00FE, 16'hBEEF, 1'b1, 1'b0, 1'b0})
      $display("[TB] FAIL store: got alu=%h wdata=%h mw=%b rw=%b mr=%b expected 00fe/beef/1/0/0",
               bus.alu_MEM, bus.wdata_MEM, bus.memWrite_MEM, bus.regWrite_MEM, bus.memRead_MEM);
    else checksPassed++;
    applyStimulus(4'hA, 4'h0, 4'h9, 16'h1111, 16'h0200, 16'h0004, C_RW | C_MR | C_MS);
    @(negedge clk);
    checksRun++;
    if ({bus.alu_MEM, bus.WA_MEM, bus.memRead_MEM, bus.memSource_MEM, bus.memWrite_MEM} !==
        {16'h0204, 4'h9, 1'b1, 1'b1, 1'b0})
      $display("[TB] FAIL load: got alu=%h wa=%h mr=%b ms=%b mw=%b expected 0204/9/1/1/0",
               bus.alu_MEM, bus.WA_MEM, bus.memRead_MEM, bus.memSource_MEM, bus.memWrite_MEM);
    else checksPassed++;
    applyStimulus(OP_NOP, 4'h0, 4'h0, 16'h0, 16'h0, 16'h0, 6'b0);
  endtask

  task automatic test_illegal_fn;
    @(negedge clk);
    applyStimulus(OP_RTYPE, 4'h7, 4'h4, 16'h0005, 16'h0003, 16'h0, C_RW | C_R0);
    #1;
    checksRun++;
    if (bus.ex_busy !== 1'b0) $display("[TB] FAIL illegal_busy: got %b expected 0", bus.ex_busy);
    else checksPassed++;
    @(negedge clk);
    checksRun++;
    if ({bus.alu_MEM, bus.regWrite_MEM, bus.r0Write_MEM, bus.memRead_MEM, bus.memWrite_MEM,
         bus.memSource_MEM} !== '0)
      $display("[TB] FAIL illegal_result: got alu=%h rw=%b r0w=%b expected 0000/0/0",
               bus.alu_MEM, bus.regWrite_MEM, bus.r0Write_MEM);
    else checksPassed++;
    applyStimulus(OP_NOP, 4'h0, 4'h0, 16'h0, 16'h0, 16'h0, 6'b0);
  endtask

  task automatic test_mul;
    int cycles;
    bit bubbleBad;
    @(negedge clk);
    applyStimulus(OP_RTYPE, FN_MUL, 4'h4, 16'hFFFD, 16'h0007, 16'h0, C_RW | C_R0);
    runLongOp(cycles, bubbleBad);
    checksRun++;
    if (cycles !== 17) $display("[TB] FAIL mul_busy_cycles: got %0d expected 17", cycles);
    else checksPassed++;
    checksRun++;
    if (bubbleBad !== 1'b0) $display("[TB] FAIL mul_bubbles: got nonzero _MEM during stall expected zero");
    else checksPassed++;
    checksRun++;
    if ({bus.alu_MEM, bus.r0_MEM, bus.WA_MEM, bus.regWrite_MEM, bus.r0Write_MEM} !==
        {16'hFFEB, 16'hFFFF, 4'h4, 1'b1, 1'b1})
      $display("[TB] FAIL mul_result: got lo=%h hi=%h wa=%h rw=%b r0w=%b expected ffeb/ffff/4/1/1",
               bus.alu_MEM, bus.r0_MEM, bus.WA_MEM, bus.regWrite_MEM, bus.r0Write_MEM);
    else checksPassed++;
    // -32768 * -1 through the immediate operand
    @(negedge clk);
    applyStimulus(OP_RTYPE, FN_MUL, 4'h6, 16'h8000, 16'h1234, 16'hFFFF, C_RW | C_R0 | C_SRC);
    runLongOp(cycles, bubbleBad);
    checksRun++;
    if ({bus.alu_MEM, bus.r0_MEM} !== {16'h8000, 16'h0000})
      $display("[TB] FAIL mul_minint: got lo=%h hi=%h expected 8000/0000", bus.alu_MEM, bus.r0_MEM);
    else checksPassed++;
  endtask

`ifdef EX_DIV_EN
  task automatic test_div;
    int cycles;
    bit bubbleBad;
    @(negedge clk);
    applyStimulus(OP_RTYPE, FN_DIV, 4'h5, 16'hFFF9, 16'h0002, 16'h0, C_RW | C_R0);
    runLongOp(cycles, bubbleBad);
    checksRun++;
    if ({cycles == 17, bubbleBad, bus.alu_MEM, bus.r0_MEM, bus.r0Write_MEM} !==
        {1'b1, 1'b0, 16'hFFFD, 16'hFFFF, 1'b1})
      $display("[TB] FAIL div_neg: got cyc=%0d q=%h r=%h r0w=%b expected 17/fffd/ffff/1",
               cycles, bus.alu_MEM, bus.r0_MEM, bus.r0Write_MEM);
    else checksPassed++;
    @(negedge clk);
    applyStimulus(OP_RTYPE, FN_DIV, 4'h5, 16'h0005, 16'h0000, 16'h0, C_RW | C_R0);
    runLongOp(cycles, bubbleBad);
    checksRun++;
    if ({cycles == 17, bus.alu_MEM, bus.r0_MEM} !== {1'b1, 16'hFFFF, 16'h0005})
      $display("[TB] FAIL div_zero: got cyc=%0d q=%h r=%h expected 17/ffff/0005",
               cycles, bus.alu_MEM, bus.r0_MEM);
    else checksPassed++;
  endtask
`else
  task automatic test_div;
    @(negedge clk);
    applyStimulus(OP_RTYPE, FN_DIV, 4'h5, 16'hFFF9, 16'h0002, 16'h0, C_RW | C_R0);
    #1;
    checksRun++;
    if (bus.ex_busy !== 1'b0) $display("[TB] FAIL div_off_busy: got %b expected 0", bus.ex_busy);
    else checksPassed++;
    @(negedge clk);
    checksRun++;
    if ({bus.alu_MEM, bus.regWrite_MEM, bus.r0Write_MEM} !== '0)
      $display("[TB] FAIL div_off_result: got alu=%h rw=%b r0w=%b expected 0000/0/0",
               bus.alu_MEM, bus.regWrite_MEM, bus.r0Write_MEM);
    else checksPassed++;
    applyStimulus(OP_NOP, 4'h0, 4'h0, 16'h0, 16'h0, 16'h0, 6'b0);
  endtask
`endif

  task automatic test_flush_run;
    @(negedge clk);
    applyStimulus(OP_RTYPE, FN_MUL, 4'h1, 16'h0003, 16'h0005, 16'h0, C_RW | C_R0);
    repeat (5) @(negedge clk);
    checksRun++;
    if (bus.ex_busy !== 1'b1) $display("[TB] FAIL flush_pre_busy: got %b expected 1", bus.ex_busy);
    else checksPassed++;
    bus.flush = 1'b1;
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    applyStimulus(OP_RTYPE, FN_ADD, 4'h6, 16'h0002, 16'h0003, 16'h0, C_RW);
    @(negedge clk);
    checksRun++;
    if ({bus.ex_busy, bus.alu_MEM, bus.r0_MEM, bus.regWrite_MEM, bus.r0Write_MEM} !== '0)
      $display("[TB] FAIL flush_bubble: got busy=%b alu=%h r0=%h rw=%b expected 0/0000/0000/0",
               bus.ex_busy, bus.alu_MEM, bus.r0_MEM, bus.regWrite_MEM);
    else checksPassed++;
    @(negedge clk);
    checksRun++;
    if ({bus.alu_MEM, bus.WA_MEM, bus.regWrite_MEM} !== {16'h0005, 4'h6, 1'b1})
      $display("[TB] FAIL flush_next_add: got alu=%h wa=%h rw=%b expected 0005/6/1",
               bus.alu_MEM, bus.WA_MEM, bus.regWrite_MEM);
    else checksPassed++;
    applyStimulus(OP_NOP, 4'h0, 4'h0, 16'h0, 16'h0, 16'h0, 6'b0);
  endtask

  task automatic test_reset_run;
    int cycles;
    bit bubbleBad;
    @(negedge clk);
    applyStimulus(OP_RTYPE, FN_MUL, 4'h7, 16'h0064, 16'hFFFE, 16'h0, C_RW);
    repeat (8) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    checksRun++;
    if ({bus.ex_busy, bus.alu_MEM, bus.r0_MEM, bus.wdata_MEM, bus.WA_MEM, bus.regWrite_MEM,
         bus.r0Write_MEM, bus.memRead_MEM, bus.memWrite_MEM, bus.memSource_MEM} !== '0)
      $display("[TB] FAIL reset_in_run: got busy=%b alu=%h wa=%h expected all zero",
               bus.ex_busy, bus.alu_MEM, bus.WA_MEM);
    else checksPassed++;
    @(negedge clk);
    reset = 1'b0;
    runLongOp(cycles, bubbleBad);
    checksRun++;
    if ({cycles == 17, bus.alu_MEM, bus.r0_MEM, bus.regWrite_MEM, bus.r0Write_MEM} !==
        {1'b1, 16'hFF38, 16'hFFFF, 1'b1, 1'b0})
      $display("[TB] FAIL restart_mul: got cyc=%0d lo=%h hi=%h rw=%b r0w=%b expected 17/ff38/ffff/1/0",
               cycles, bus.alu_MEM, bus.r0_MEM, bus.regWrite_MEM, bus.r0Write_MEM);
    else checksPassed++;
  endtask

  initial begin
    checksRun    = 0;
    checksPassed = 0;
    test_reset();
    test_add();
    test_back_to_back();
    test_store();
    test_illegal_fn();
    test_mul();
    test_div();
    test_flush_run();
    test_reset_run();
    $display("%0d/%0d checks passed", checksPassed, checksRun);
    $finish;
  end

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage of the 16-bit pipelined CPU. It consumes the ID/EX pipeline register outputs (opcode, register addresses, function/offset field, operands, sign-extended offset, control bits).
- Single-cycle ALU ops: ADD, SUB, AND, OR, and address generation. Signed MUL and DIV run on an iterative multi-cycle unit that stalls the front end through `ex_busy`.
- Owns the EX/MEM pipeline register that feeds the memory stage.

Parameters:
- WIDTH, 16, datapath width. The multiply/divide iteration count equals WIDTH.
- CNT_W, 4, iteration counter width; must satisfy 2^CNT_W = WIDTH.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- flush  in  1  kill the current EX instruction; a bubble enters EX/MEM
- opcode_EX  in  4  opcode from ID/EX
- RA1_EX, RA2_EX  in  4  register addresses; RA1_EX is the destination
- FN_offset_EX  in  4  R-type function code
- RD1_EX, RD2_EX  in  WIDTH  register operands
- SE_offset_EX  in  WIDTH  sign-extended immediate
- regWrite_EX, r0Write_EX, alusource_EX, memRead_EX, memWrite_EX, memSource_EX  in  1  control bits
- ex_busy  out  1  combinational stall request to the PC, IF/ID and ID/EX
- alu_MEM  out  WIDTH  main result (Rd data or memory address)
- r0_MEM  out  WIDTH  R0 write data (MUL high half, DIV remainder)
- wdata_MEM  out  WIDTH  store data
- WA_MEM  out  4  destination address
- regWrite_MEM, r0Write_MEM, memRead_MEM, memWrite_MEM, memSource_MEM  out  1  registered control bits

Behaviour:
- Reset clears every `_MEM` output and drives `ex_busy` to 0. The FSM goes to IDLE and the counter to 0. Reset overrides flush and aborts any in-flight MUL/DIV.
- Operand selection:
  - For R-type (opcode 4'b0000): A = RD1, B = alusource ? SE_offset : RD2.
  - For any opcode with memRead|memWrite: alu = RD2 + SE_offset, and wdata = RD1.
  - All other opcodes: alu = A + B, and wdata = RD1.
- FN codes (R-type only): 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 MUL, 0101 DIV. Any other FN gives alu = 0 and all write/mem enables are forced to 0.
- Arithmetic wraps modulo 2^WIDTH. No overflow flag.
- Single-cycle ops have a latency of 1: values present in cycle t appear on the `_MEM` outputs after the edge that ends cycle t. `r0_MEM` = 0 for these ops.
- FSM states:
  - IDLE: if the instruction is MUL/DIV and flush = 0, then ex_busy = 1. The block latches the absolute values of A and B and their signs, clears the counter, and moves to RUN.
  - RUN: one shift-add (MUL) or restoring-subtract (DIV) step per cycle; ex_busy = 1. When the counter reaches WIDTH-1, the FSM moves to DONE.
  - DONE: ex_busy = 0. Sign fix-up is applied. The result is captured into EX/MEM on this edge and the FSM returns to IDLE.
- MUL/DIV timing:
  - ex_busy is high for WIDTH+1 cycles (17 cycles at default).
  - The result is on the `_MEM` outputs after cycle t+WIDTH+1.
  - While ex_busy = 1, EX/MEM captures a bubble: all enables 0, data 0.
- MUL: 32-bit signed product. Low half goes to alu_MEM, high half to r0_MEM.
- DIV: signed division truncating toward zero. The remainder takes the sign of the dividend. Quotient goes to alu_MEM, remainder to r0_MEM.
- Divide by zero: quotient = 16'hFFFF, remainder = dividend. The op still takes the full latency.
- Flush:
  - In IDLE or DONE, the bubble replaces the capture.
  - In RUN, the operation aborts: FSM to IDLE, ex_busy drops to 0 the next cycle, and a bubble is captured.
- The upstream ID/EX holds its contents while ex_busy = 1. The DONE cycle does not restart, because ID/EX advances on that edge.

Optional Feature:
- EX_DIV_EN defined: DIV is implemented as specified above.
- EX_DIV_EN undefined: FN 0101 is treated as an illegal FN (alu = 0, enables forced to 0, no stall). The divider datapath is not synthesised.

Decomposition:
- Package `cpu_pkg` holds:
  - OP_RTYPE, FN_ADD, FN_SUB, FN_AND, FN_OR, FN_MUL, FN_DIV;
  - WIDTH default;
  - the FSM state typedef (IDLE, RUN, DONE).
- Sub-module `muldiv_seq`: iterative signed multiply/divide. It owns the FSM, counter, and sign fix-up, and exposes start/busy/done/hi/lo. `ex_stage` keeps the ALU, operand selection, and EX/MEM register.

Test Plan:
- ADD: R-type FN 0000, RD1 = 16'h7FFF, RD2 = 16'h0001, regWrite = 1, RA1 = 3 -> next cycle alu_MEM = 16'h8000, WA_MEM = 3, regWrite_MEM = 1, ex_busy stays 0.
- Store: memWrite = 1, RD2 = 16'h0100, SE = 16'hFFFE, RD1 = 16'hBEEF -> alu_MEM = 16'h00FE, wdata_MEM = 16'hBEEF, memWrite_MEM = 1.
- MUL: A = -3 (16'hFFFD), B = 7 -> ex_busy high 17 cycles, bubbles on `_MEM` during that time, then alu_MEM = 16'hFFEB, r0_MEM = 16'hFFFF, r0Write_MEM = 1.
- DIV: A = -7, B = 2 -> quotient 16'hFFFD, remainder 16'hFFFF. DIV by 0 with A = 5 -> 16'hFFFF / 16'h0005. Without EX_DIV_EN -> enables 0, no stall.
- Flush in RUN cycle 5 of MUL -> ex_busy 0 next cycle, bubble on `_MEM`. A following ADD completes normally one cycle later.
- Reset asserted in RUN cycle 8 -> all `_MEM` outputs 0 and ex_busy = 0 after the edge. The FSM restarts cleanly on a new MUL.
